// File: rtl/pe_psum_accumulator_pkg.sv
// Package for the PE partial-sum accumulator: fixed-point format constants,
// datapath types and the accumulator-to-result saturation helpers.
package psum_pkg;

    localparam int DATA_W     = 16;
    localparam int FRAC_BITS  = 7;
    localparam int ACC_W      = 24;
    localparam int PE_LATENCY = 5;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam data_t SAT_MAX = 16'h7FFF;
    localparam data_t SAT_MIN = 16'h8000;

    // Result limits widened to accumulator width so that comparisons stay signed.
    localparam acc_t ACC_SAT_MAX = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
    localparam acc_t ACC_SAT_MIN = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

    // Clamp an accumulator value into the result range.
    function automatic data_t sat_to_data(input acc_t acc);
        if (acc > ACC_SAT_MAX) begin
            return SAT_MAX;
        end else if (acc < ACC_SAT_MIN) begin
            return SAT_MIN;
        end else begin
            return acc[DATA_W-1:0];
        end
    endfunction

    // True when sat_to_data would have to clamp this value.
    function automatic logic sat_hit(input acc_t acc);
        return (acc > ACC_SAT_MAX) || (acc < ACC_SAT_MIN);
    endfunction

endpackage

// File: rtl/pe_psum_accumulator_valid_delay.sv
// pe_valid_delay: issue-pulse delay line that advances in lock-step with the
// PE pipeline (same en/clr), so tap k is high when the chunk issued k+1
// enabled edges ago is k+1 stages deep.
module pe_valid_delay
    import psum_pkg::*;
#(
    parameter int WIDTH = PE_LATENCY + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Shift on enabled edges only; clr empties the line like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/pe_psum_accumulator.sv
// pe_psum_accumulator: accumulates NUM_CHUNKS consecutive PE tree-adder
// results plus a bias into one neuron pre-activation, saturates it to
// DATA_W bits and emits it with a one-cycle y_valid pulse.
// Optional build macro PE_PSUM_ACCUMULATOR_RELU_EN: clamp negative results
// to zero after saturation (ovf still reflects the pre-ReLU saturation).
module pe_psum_accumulator
    import psum_pkg::*;
#(
    parameter int DATA_W     = psum_pkg::DATA_W,
    parameter int FRAC_BITS  = psum_pkg::FRAC_BITS,
    parameter int ACC_W      = psum_pkg::ACC_W,
    parameter int NUM_CHUNKS = 4,
    parameter int PE_LATENCY = psum_pkg::PE_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     issue,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] pe_out,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     ovf
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    logic [PE_LATENCY:0] vld_sr;

    logic                    capture_p0;
    logic                    first_p0;
    logic                    last_p0;
    logic signed [ACC_W-1:0] bias_ext_p0;
    logic signed [ACC_W-1:0] pe_ext_p0;
    logic signed [ACC_W-1:0] acc_base_p0;
    logic signed [ACC_W-1:0] acc_next_p0;
    logic signed [DATA_W-1:0] sat_p0;
    logic                     sat_hit_p0;
    logic signed [DATA_W-1:0] y_next_p0;

    logic signed [ACC_W-1:0]  acc_p1;
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] y_p1;
    logic                     y_valid_p1;
    logic                     ovf_p1;

    // The top tap of the line and the format description are carried for
    // readability and for downstream users; they do not steer any logic here.
    logic unused_bits;
    assign unused_bits = vld_sr[PE_LATENCY] | (FRAC_BITS < 0);

    pe_valid_delay #(
        .WIDTH (PE_LATENCY + 1)
    ) u_valid_delay (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr),
        .din (issue),
        .q   (vld_sr)
    );

    // ---- p0: capture decision and next accumulator value (combinational) ----
    // The PE result for a chunk is present when its issue pulse reaches tap
    // PE_LATENCY-1, i.e. on the (PE_LATENCY+1)th enabled edge from issue.
    always_comb begin
        capture_p0  = en & vld_sr[PE_LATENCY-1];
        first_p0    = (cnt == '0);
        last_p0     = (cnt == CNT_LAST);
        bias_ext_p0 = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
        pe_ext_p0   = {{(ACC_W-DATA_W){pe_out[DATA_W-1]}}, pe_out};
        acc_base_p0 = first_p0 ? bias_ext_p0 : acc_p1;
        acc_next_p0 = acc_base_p0 + pe_ext_p0;
        sat_p0      = sat_to_data(acc_next_p0);
        sat_hit_p0  = sat_hit(acc_next_p0);
`ifdef PE_PSUM_ACCUMULATOR_RELU_EN
        y_next_p0   = sat_p0[DATA_W-1] ? '0 : sat_p0;
`else
        y_next_p0   = sat_p0;
`endif
    end

    // ---- p1: accumulator, chunk counter and registered result ----
    // The counter wraps on the last chunk so a following neuron can start on
    // the very next capture without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1     <= '0;
            cnt        <= '0;
            y_p1       <= '0;
            y_valid_p1 <= 1'b0;
            ovf_p1     <= 1'b0;
        end else if (clr) begin
            acc_p1     <= '0;
            cnt        <= '0;
            y_p1       <= '0;
            y_valid_p1 <= 1'b0;
            ovf_p1     <= 1'b0;
        end else begin
            y_valid_p1 <= 1'b0;
            if (capture_p0) begin
                acc_p1 <= acc_next_p0;
                if (last_p0) begin
                    cnt        <= '0;
                    y_p1       <= y_next_p0;
                    y_valid_p1 <= 1'b1;
                    if (sat_hit_p0) begin
                        ovf_p1 <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign y       = y_p1;
    assign y_valid = y_valid_p1;
    assign ovf     = ovf_p1;
    assign busy    = (|vld_sr[PE_LATENCY-1:0]) | (cnt != '0);

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Bench for pe_psum_accumulator: a behavioural PE-latency model feeds pe_out,
// stimulus pushes expected results into a scoreboard queue and a monitor on
// the falling edge pops and compares whenever y_valid is high.
module tb_pe_psum_accumulator;

    localparam int LAT = 5;

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        issue;
    logic [15:0] issue_val;
    logic [15:0] bias;
    logic [15:0] pe_out;
    logic [15:0] y;
    logic        y_valid;
    logic        busy;
    logic        ovf;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    logic [15:0] pe_pipe [LAT];

    pe_psum_accumulator #(
        .NUM_CHUNKS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .issue   (issue),
        .bias    (bias),
        .pe_out  (pe_out),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the PE: the issued value appears on pe_out after LAT enabled edges.
    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int i = 0; i < LAT; i++) pe_pipe[i] <= 16'h0;
        end else if (en) begin
            pe_pipe[0] <= issue ? issue_val : 16'h0;
            for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
        end
    end
    assign pe_out = pe_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_y_valid: got y=%h with no result pending (cycle %0d)", y, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("y", 32'(y), 32'(e.y));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("y_valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_chunk(input logic [15:0] v);
        issue     = 1'b1;
        issue_val = v;
        step();
        issue     = 1'b0;
        issue_val = 16'h0;
    endtask

    task automatic run_neuron(input logic [15:0] b,
                              input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3,
                              input logic [15:0] ey, input logic eovf,
                              input int stall);
        bias = b;
        issue_chunk(v0);
        issue_chunk(v1);
        issue_chunk(v2);
        issue_chunk(v3);
        exp_q.push_back(exp_t'{ey, eovf, cyc + 5 + stall});
        if (stall > 0) begin
            en = 1'b0;
            repeat (stall) step();
            en = 1'b1;
        end
    endtask

    task automatic drain();
        repeat (10) step();
    endtask

    initial begin
        logic [15:0] relu_exp;
        rst       = 1'b1;
        en        = 1'b1;
        clr       = 1'b0;
        issue     = 1'b0;
        issue_val = 16'h0;
        bias      = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_y_valid", 32'(y_valid), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();

        // Nominal neuron.
        run_neuron(16'h0080, 16'h0100, 16'h0080, 16'hFF80, 16'h0040, 16'h01C0, 1'b0, 0);
        chk("busy_inflight", 32'(busy), 32'h1);
        drain();
        chk("busy_idle", 32'(busy), 32'h0);

        // Back-to-back neurons, no bubble between them.
        bias = 16'h0080;
        issue_chunk(16'h0100);
        issue_chunk(16'h0080);
        issue_chunk(16'hFF80);
        issue_chunk(16'h0040);
        exp_q.push_back(exp_t'{16'h01C0, 1'b0, cyc + 5});
        issue_chunk(16'h0010);
        issue_chunk(16'h0010);
        issue_chunk(16'h0010);
        issue_chunk(16'h0010);
        exp_q.push_back(exp_t'{16'h00C0, 1'b0, cyc + 5});
        drain();

        // Stall of 3 cycles between issue and capture.
        run_neuron(16'h0080, 16'h0100, 16'h0080, 16'hFF80, 16'h0040, 16'h01C0, 1'b0, 3);
        drain();

        // Positive saturation, then clr.
        run_neuron(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b1, 0);
        drain();
        chk("ovf_sticky", 32'(ovf), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'h0);
        chk("clr_y", 32'(y), 32'h0);

        // Negative saturation.
        run_neuron(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 1'b1, 0);
        drain();

        // Asynchronous reset mid-neuron: one chunk captured, one still in flight.
        bias = 16'h0100;
        issue_chunk(16'h0100);
        issue_chunk(16'h0100);
        repeat (4) step();
        chk("busy_before_rst", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_y", 32'(y), 32'h0);
        chk("async_rst_y_valid", 32'(y_valid), 32'h0);
        chk("async_rst_ovf", 32'(ovf), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        drain();

        // clr after two of four captures, then a fresh neuron.
        bias = 16'h0400;
        issue_chunk(16'h0200);
        issue_chunk(16'h0200);
        issue_chunk(16'h0200);
        issue_chunk(16'h0200);
        repeat (3) step();
        chk("busy_before_clr", 32'(busy), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("busy_after_clr", 32'(busy), 32'h0);
        run_neuron(16'h0100, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0140, 1'b0, 0);
        drain();

        // Negative non-saturating result: ReLU build clamps to zero.
`ifdef PE_PSUM_ACCUMULATOR_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFF40;
`endif
        run_neuron(16'hFF00, 16'h0010, 16'h0010, 16'h0010, 16'h0010, relu_exp, 1'b0, 0);
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
